// File: rtl/image_mem_arbiter_if.sv
// Bus bundle between the display/loader requesters, the image RAM arbiter and the RAM.
// The slave view is the arbiter's: it serves requests and drives the RAM strobe.
interface image_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 16
);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_rdata, disp_rvalid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_rdata, disp_rvalid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM arbiter: display reads win every cycle with fixed 2-cycle latency,
// loader writes queue in a small FIFO and drain into idle (optionally vblank-only) cycles.
module image_mem_arbiter #(
  parameter int AW          = 14,
  parameter int DW          = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int VBLANK_ONLY = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vblank,
  image_mem_arbiter_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drain_ok;
  logic [1:0]    cmd_p0;
  logic          rd_tag_p1;

  // Ready comes from the registered level only, so a full FIFO never takes a same-cycle pop credit.
  assign bus.wr_ready = (fifo_level < LW'(FIFO_DEPTH));
  assign push         = bus.wr_valid & bus.wr_ready;
  assign drain_ok     = (VBLANK_ONLY == 0) || vblank;
  assign pop          = !bus.disp_req && (fifo_level != '0) && drain_ok;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Stage p0: command register driving the RAM strobe; address/data hold while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_p0        <= CMD_IDLE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (bus.disp_req) begin
      cmd_p0       <= CMD_READ;
      bus.mem_addr <= bus.disp_addr;
    end else if (pop) begin
      cmd_p0        <= CMD_WRITE;
      bus.mem_addr  <= fifo_addr[rd_ptr];
      bus.mem_wdata <= fifo_data[rd_ptr];
    end else begin
      cmd_p0 <= CMD_IDLE;
    end
  end

  assign bus.mem_en = (cmd_p0 != CMD_IDLE);
  assign bus.mem_we = (cmd_p0 == CMD_WRITE);

  // Stage p1/p2: read tag tracks the RAM's one-cycle output, then data is captured for display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tag_p1       <= 1'b0;
      bus.disp_rvalid <= 1'b0;
      bus.disp_rdata  <= '0;
    end else begin
      rd_tag_p1       <= (cmd_p0 == CMD_READ);
      bus.disp_rvalid <= rd_tag_p1;
      if (rd_tag_p1) bus.disp_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_image_mem_arbiter.sv
// Bench for image_mem_arbiter: scoreboarded reads/writes on a default instance plus
// directed checks on a vblank-gated instance, both against behavioural RAM models.
module tb_image_mem_arbiter;
  logic clk;
  logic rst;
  logic vblank_a;
  logic vblank_b;
  logic [2:0] level_a;
  logic [2:0] level_b;
  int cyc;
  int n_chk;
  int n_err;
  int nwr_b;

  typedef struct { logic [15:0] data; int stamp; } rd_exp_t;
  typedef struct { logic [13:0] addr; logic [15:0] data; } wr_exp_t;
  rd_exp_t rq[$];
  wr_exp_t wq[$];
  int      wcyc[$];

  logic [15:0] ram_a [0:16383];
  logic [15:0] ram_b [0:16383];
  logic [15:0] gold  [0:16383];

  image_mem_arbiter_if #(.AW(14), .DW(16)) ifa ();
  image_mem_arbiter_if #(.AW(14), .DW(16)) ifb ();

  image_mem_arbiter #(.AW(14), .DW(16), .FIFO_DEPTH(4), .VBLANK_ONLY(0)) dut_a (
    .clk(clk), .rst(rst), .vblank(vblank_a), .bus(ifa), .fifo_level(level_a)
  );

  image_mem_arbiter #(.AW(14), .DW(16), .FIFO_DEPTH(4), .VBLANK_ONLY(1)) dut_b (
    .clk(clk), .rst(rst), .vblank(vblank_b), .bus(ifb), .fifo_level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (ifa.mem_en) begin
      if (ifa.mem_we) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
      else            ifa.mem_rdata <= ram_a[ifa.mem_addr];
    end
    if (ifb.mem_en) begin
      if (ifb.mem_we) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
      else            ifb.mem_rdata <= ram_b[ifb.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t r;
    wr_exp_t w;
    if (!rst) begin
      if (ifa.disp_rvalid) begin
        if (rq.size() == 0) chk("rd_unexpected", ifa.disp_rvalid, 0);
        else begin
          r = rq.pop_front();
          chk("rd_data", ifa.disp_rdata, r.data);
          chk("rd_latency", cyc, r.stamp + 2);
        end
      end
      if (ifa.mem_en && ifa.mem_we) begin
        wcyc.push_back(cyc);
        if (wq.size() == 0) chk("wr_unexpected", ifa.mem_we, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", ifa.mem_addr, w.addr);
          chk("wr_data", ifa.mem_wdata, w.data);
        end
      end
    end
  end

  always @(negedge clk) if (!rst && ifb.mem_en && ifb.mem_we) nwr_b <= nwr_b + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit req, input logic [13:0] a, input bit wv,
                      input logic [13:0] wa, input logic [15:0] wd);
    rd_exp_t r;
    wr_exp_t w;
    ifa.disp_req  = req;
    ifa.disp_addr = a;
    ifa.wr_valid  = wv;
    ifa.wr_addr   = wa;
    ifa.wr_data   = wd;
    if (req) begin
      r.data  = gold[a];
      r.stamp = cyc + 1;
      rq.push_back(r);
    end
    if (wv && ifa.wr_ready) begin
      w.addr = wa;
      w.data = wd;
      wq.push_back(w);
    end
    tick();
    ifa.wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    cyc = 0; n_chk = 0; n_err = 0; nwr_b = 0;
    rst = 1'b1; vblank_a = 1'b0; vblank_b = 1'b0;
    ifa.disp_req = 0; ifa.disp_addr = 0; ifa.wr_valid = 0; ifa.wr_addr = 0; ifa.wr_data = 0;
    ifb.disp_req = 0; ifb.disp_addr = 0; ifb.wr_valid = 0; ifb.wr_addr = 0; ifb.wr_data = 0;
    for (int i = 0; i < 16384; i++) begin
      ram_a[i] <= init_val(i);
      ram_b[i] <= init_val(i);
      gold[i]   = init_val(i);
    end
    ram_a[5] <= 16'hABCD;
    gold[5]   = 16'hABCD;

    tick(); tick();
    chk("rst_rvalid", ifa.disp_rvalid, 0);
    chk("rst_rdata", ifa.disp_rdata, 0);
    chk("rst_wr_ready", ifa.wr_ready, 1);
    chk("rst_mem_en", ifa.mem_en, 0);
    chk("rst_mem_we", ifa.mem_we, 0);
    chk("rst_mem_addr", ifa.mem_addr, 0);
    chk("rst_mem_wdata", ifa.mem_wdata, 0);
    chk("rst_level", level_a, 0);
    rst = 1'b0;
    tick();

    // Single read latency, then 640 back-to-back reads
    step(1'b1, 14'h0005, 1'b0, 14'h0, 16'h0);
    idle(4);
    for (int i = 0; i < 640; i++) step(1'b1, 14'(14'h0200 + i), 1'b0, 14'h0, 16'h0);
    idle(4);
    chk("burst_drained", rq.size(), 0);

    // Priority: writes wait behind continuous reads, then drain back to back
    wcyc.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 14'h0300, 1'b1, 14'(14'h0400 + i), 16'(16'hC000 + i));
    step(1'b1, 14'h0300, 1'b0, 14'h0, 16'h0);
    step(1'b1, 14'h0300, 1'b0, 14'h0, 16'h0);
    chk("prio_no_write", wcyc.size(), 0);
    chk("prio_level", level_a, 3);
    t0 = cyc;
    idle(5);
    chk("prio_wr_count", wcyc.size(), 3);
    for (int i = 0; i < 3 && i < wcyc.size(); i++) chk("prio_wr_cycle", wcyc[i], t0 + 1 + i);
    for (int i = 0; i < 3; i++) gold[14'h0400 + i] = 16'(16'hC000 + i);

    // Full FIFO: 5th offer refused, one pop frees a slot next cycle
    for (int i = 0; i < 4; i++) step(1'b1, 14'h0300, 1'b1, 14'(14'h0500 + i), 16'(16'hD000 + i));
    chk("full_level", level_a, 4);
    chk("full_ready", ifa.wr_ready, 0);
    step(1'b1, 14'h0300, 1'b1, 14'h0599, 16'hEEEE);
    chk("full_refused", level_a, 4);
    step(1'b0, 14'h0, 1'b0, 14'h0, 16'h0);
    chk("pop_ready", ifa.wr_ready, 1);
    chk("pop_level", level_a, 3);
    idle(6);
    chk("full_drained", wq.size(), 0);
    chk("full_level_0", level_a, 0);
    for (int i = 0; i < 4; i++) gold[14'h0500 + i] = 16'(16'hD000 + i);

    // Hazard: read of a still-queued address returns old contents
    step(1'b0, 14'h0, 1'b1, 14'h0020, 16'h5555);
    step(1'b1, 14'h0020, 1'b0, 14'h0, 16'h0);
    idle(4);
    gold[14'h0020] = 16'h5555;
    step(1'b1, 14'h0020, 1'b0, 14'h0, 16'h0);
    idle(4);
    chk("hazard_drained", rq.size(), 0);

    // Vblank-gated instance
    ifb.wr_valid = 1'b1; ifb.wr_addr = 14'h0010; ifb.wr_data = 16'h1111;
    tick();
    ifb.wr_addr = 14'h0011; ifb.wr_data = 16'h2222;
    tick();
    ifb.wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("vb_held", nwr_b, 0);
    chk("vb_level", level_b, 2);
    vblank_b = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("vb_written", nwr_b, 2);
    chk("vb_level_0", level_b, 0);
    vblank_b = 1'b0;
    ifb.disp_req = 1'b1; ifb.disp_addr = 14'h0010;
    tick();
    ifb.disp_addr = 14'h0011;
    tick();
    ifb.disp_req = 1'b0;
    tick();
    chk("vb_rd0_valid", ifb.disp_rvalid, 1);
    chk("vb_rd0_data", ifb.disp_rdata, 16'h1111);
    tick();
    chk("vb_rd1_valid", ifb.disp_rvalid, 1);
    chk("vb_rd1_data", ifb.disp_rdata, 16'h2222);
    tick();
    chk("vb_rd_end", ifb.disp_rvalid, 0);

    // Reset mid-read with two writes queued
    step(1'b1, 14'h0300, 1'b1, 14'h0600, 16'h1234);
    step(1'b1, 14'h0300, 1'b1, 14'h0601, 16'h5678);
    step(1'b1, 14'h0310, 1'b0, 14'h0, 16'h0);
    ifa.disp_req = 1'b0;
    #1;
    rst = 1'b1;
    rq.delete();
    wq.delete();
    #1;
    chk("arst_rvalid", ifa.disp_rvalid, 0);
    chk("arst_mem_en", ifa.mem_en, 0);
    chk("arst_level", level_a, 0);
    chk("arst_ready", ifa.wr_ready, 1);
    tick();
    rst = 1'b0;
    wcyc.delete();
    idle(6);
    chk("arst_no_write", wcyc.size(), 0);
    chk("arst_rvalid_after", ifa.disp_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
